// File: rtl/lane_follower.sv
// lane_follower: one obstacle lane (road row plus one car) at the consumer end
// of the vertical-scroll interface.
//
// The lane row steps by MOVE_AMT on every move_followers pulse. It uses the same
// step/wrap arithmetic as the scroller, so it stays locked to the background.
// The car moves horizontally on a private tick of CAR_SPEED_DIV clocks. A sticky
// collision flag is raised when the player reference point lies inside the
// car's box. After a collision the lane freezes until reset.
//
// Ports:
//   clk             in   1   pixel clock
//   reset           in   1   synchronous, active-high
//   move_followers  in   1   one-cycle scroll pulse from the scroller
//   player_x        in   10  player sprite reference x
//   player_y        in   10  player sprite reference y
//   lane_y          out  10  lane top row (registered)
//   car_x           out  10  car left column (registered)
//   wrapped         out  1   one-cycle pulse: lane wrapped to the top
//   hit             out  1   sticky collision flag (registered)
module lane_follower #(
    parameter int ROW_INIT      = 240,
    parameter int MOVE_AMT      = 2,
    parameter int SCREEN_H      = 480,
    parameter int SCREEN_W      = 640,
    parameter int LANE_H        = 32,
    parameter int CAR_W         = 48,
    parameter int CAR_SPEED_DIV = 62500,
    parameter int CAR_STEP      = 1,
    parameter bit DIR           = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       move_followers,
    input  logic [9:0] player_x,
    input  logic [9:0] player_y,
    output logic [9:0] lane_y,
    output logic [9:0] car_x,
    output logic       wrapped,
    output logic       hit
);

    localparam int TICK_W = (CAR_SPEED_DIV > 1) ? $clog2(CAR_SPEED_DIV) : 1;
    // A right-moving car enters from the left edge.
    // A left-moving car enters flush with the right edge.
    localparam logic [9:0] START = DIR ? 10'(SCREEN_W - CAR_W) : 10'd0;

    typedef enum logic {RUN, HIT} state_t;

    state_t              state, state_nxt;
    logic [TICK_W-1:0]   tick_ctr, tick_nxt;
    logic [9:0]          lane_y_nxt, car_x_nxt;
    logic                wrapped_nxt, hit_nxt;
    logic                lane_wrap, tick_done, overlap;

    // Sum is formed in 11 bits so that values near the top of the 10-bit
    // range cannot alias back below the wrap bound.
    function automatic logic lane_would_wrap(input logic [9:0] y);
        logic [10:0] sum;
        sum = {1'b0, y} + 11'(MOVE_AMT);
        return sum >= 11'(SCREEN_H);
    endfunction

    function automatic logic [9:0] car_step(input logic [9:0] x);
        logic [10:0] sum;
        if (!DIR) begin
            sum = {1'b0, x} + 11'(CAR_STEP);
            return (sum >= 11'(SCREEN_W)) ? 10'd0 : sum[9:0];
        end else begin
            return ({1'b0, x} < 11'(CAR_STEP)) ? 10'(SCREEN_W - CAR_W)
                                                : 10'(x - 10'(CAR_STEP));
        end
    endfunction

    // The collision box is compared in 11 bits.
    // The far edges are not wrapped around the screen.
    function automatic logic in_box(input logic [9:0] p, input logic [9:0] lo, input int size);
        logic [10:0] hi;
        hi = {1'b0, lo} + 11'(size - 1);
        return ({1'b0, p} >= {1'b0, lo}) && ({1'b0, p} <= hi);
    endfunction

    assign lane_wrap = lane_would_wrap(lane_y);
    assign tick_done = (tick_ctr == TICK_W'(CAR_SPEED_DIV - 1));
    assign overlap   = in_box(player_x, car_x, CAR_W) && in_box(player_y, lane_y, LANE_H);

    always_comb begin
        state_nxt   = state;
        lane_y_nxt  = lane_y;
        car_x_nxt   = car_x;
        tick_nxt    = tick_ctr;
        wrapped_nxt = 1'b0;
        hit_nxt     = hit;
        if (state == RUN) begin
            if (move_followers) begin
                if (lane_wrap) begin
                    lane_y_nxt  = 10'd0;
                    wrapped_nxt = 1'b1;
                end else begin
                    lane_y_nxt  = lane_y + 10'(MOVE_AMT);
                end
            end
            if (tick_done) begin
                tick_nxt  = '0;
                car_x_nxt = car_step(car_x);
            end else begin
                tick_nxt  = tick_ctr + TICK_W'(1);
            end
            // A lane that wraps respawns its car.
            // The respawn takes priority over a car step in the same cycle.
            if (move_followers && lane_wrap) begin
                car_x_nxt = START;
                tick_nxt  = '0;
            end
            // The hit is taken from the current registered positions.
            // The scroll above is still applied on this edge.
            if (overlap) begin
                state_nxt = HIT;
                hit_nxt   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RUN;
            lane_y   <= 10'(ROW_INIT);
            car_x    <= START;
            tick_ctr <= '0;
            wrapped  <= 1'b0;
            hit      <= 1'b0;
        end else begin
            state    <= state_nxt;
            lane_y   <= lane_y_nxt;
            car_x    <= car_x_nxt;
            tick_ctr <= tick_nxt;
            wrapped  <= wrapped_nxt;
            hit      <= hit_nxt;
        end
    end

endmodule

// File: tb/tb_lane_follower.sv
// Bench for lane_follower.
// Two instances share one clock:
//   dut   moves its car right (DIR=0).
//   dut_l moves its car left (DIR=1).
// Both instances use CAR_SPEED_DIV=4.
// On every cycle an independent behavioural model of the lane pushes the
// expected outputs of dut. The outputs are popped and compared after the edge.
module tb_lane_follower;

    logic       clk = 1'b0;
    logic       reset;
    logic       move_followers;
    logic [9:0] player_x, player_y;
    logic [9:0] lane_y, car_x, lane_y_l, car_x_l;
    logic       wrapped, hit, wrapped_l, hit_l;

    always #5 clk = ~clk;

    lane_follower #(.CAR_SPEED_DIV(4), .DIR(1'b0)) dut (
        .clk(clk), .reset(reset), .move_followers(move_followers),
        .player_x(player_x), .player_y(player_y),
        .lane_y(lane_y), .car_x(car_x), .wrapped(wrapped), .hit(hit));

    lane_follower #(.CAR_SPEED_DIV(4), .DIR(1'b1)) dut_l (
        .clk(clk), .reset(reset), .move_followers(move_followers),
        .player_x(player_x), .player_y(player_y),
        .lane_y(lane_y_l), .car_x(car_x_l), .wrapped(wrapped_l), .hit(hit_l));

    typedef struct {
        int lane;
        int car;
        int wr;
        int hit;
    } exp_t;

    typedef struct {
        int px;
        int py;
        int exp_hit;
    } vec_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   m_lane, m_car, m_tick, m_wr, m_hit;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Behavioural model of one clock edge, written directly from the lane's rules.
    task automatic model(input logic mf, input int px, input int py, input logic rst);
        int ov, wrap;
        if (rst) begin
            m_lane = 240; m_car = 0; m_tick = 0; m_wr = 0; m_hit = 0;
        end else if (m_hit != 0) begin
            m_wr = 0;
        end else begin
            ov   = (px >= m_car && px <= m_car + 47 && py >= m_lane && py <= m_lane + 31) ? 1 : 0;
            wrap = (mf && m_lane + 2 >= 480) ? 1 : 0;
            m_wr = wrap;
            if (mf) m_lane = (wrap != 0) ? 0 : m_lane + 2;
            if (m_tick == 3) begin
                m_tick = 0;
                m_car  = (m_car + 1 >= 640) ? 0 : m_car + 1;
            end else begin
                m_tick++;
            end
            if (wrap != 0) begin m_car = 0; m_tick = 0; end
            if (ov != 0) m_hit = 1;
        end
    endtask

    // Drive one cycle and push the model's expectation.
    // Wait for the edge, then pop the expectation and compare it with dut.
    task automatic step(input logic mf, input logic rst);
        exp_t e;
        reset = rst;
        move_followers = mf;
        model(mf, int'(player_x), int'(player_y), rst);
        sb_q.push_back('{m_lane, m_car, m_wr, m_hit});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("sb_lane_y",  32'(lane_y),  e.lane);
        check("sb_car_x",   32'(car_x),   e.car);
        check("sb_wrapped", 32'(wrapped), e.wr);
        check("sb_hit",     32'(hit),     e.hit);
        reset = 1'b0;
        move_followers = 1'b0;
    endtask

    task automatic far_player();
        player_x = 10'd1000;
        player_y = 10'd1000;
    endtask

    vec_t vecs[6];

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish, want finish");
        $fatal(1);
    end

    initial begin
        int seen_wrap;
        vecs[0] = '{48, 250, 0};
        vecs[1] = '{20, 272, 0};
        vecs[2] = '{47, 271, 1};
        vecs[3] = '{0, 240, 1};
        vecs[4] = '{20, 239, 0};
        vecs[5] = '{47, 250, 1};

        reset = 1'b1;
        move_followers = 1'b0;
        far_player();
        @(negedge clk);

        // Reset is held for two cycles.
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        check("rst_lane_y",  32'(lane_y),   240);
        check("rst_car_x",   32'(car_x),    0);
        check("rst_hit",     32'(hit),      0);
        check("rst_wrapped", 32'(wrapped),  0);
        check("rst_car_x_l", 32'(car_x_l),  592);

        // Ten back-to-back scroll pulses.
        // Car ticks fall in among them.
        seen_wrap = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0);
            if (wrapped) seen_wrap = 1;
        end
        check("scroll_lane_y", 32'(lane_y), 260);
        check("scroll_nowrap", 32'(seen_wrap), 0);

        // Scroll up to 478, then wrap.
        for (int i = 0; i < 109; i++) step(1'b1, 1'b0);
        check("pre_wrap_lane_y", 32'(lane_y), 478);
        step(1'b1, 1'b0);
        check("wrap_lane_y",  32'(lane_y),  0);
        check("wrap_wrapped", 32'(wrapped), 1);
        check("wrap_car_x",   32'(car_x),   0);
        step(1'b0, 1'b0);
        check("wrap_pulse_end", 32'(wrapped), 0);
        // tick_ctr restarted at the wrap.
        // The first step after the wrap lands on the fourth edge.
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("wrap_tick_hold", 32'(car_x), 0);
        step(1'b0, 1'b0);
        check("wrap_tick_step", 32'(car_x), 1);

        // Car motion and horizontal wrap, for both directions.
        step(1'b0, 1'b1);
        for (int i = 0; i < 40; i++) step(1'b0, 1'b0);
        check("car_40_cycles", 32'(car_x), 10);
        step(1'b0, 1'b1);
        for (int i = 0; i < 2368; i++) step(1'b0, 1'b0);
        check("car_l_at_zero", 32'(car_x_l), 0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
        check("car_l_wrap", 32'(car_x_l), 592);
        for (int i = 0; i < 2556 - 2372; i++) step(1'b0, 1'b0);
        check("car_at_639", 32'(car_x), 639);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
        check("car_wrap", 32'(car_x), 0);

        // Hit, followed by a frozen lane.
        step(1'b0, 1'b1);
        player_x = 10'd20;
        player_y = 10'd250;
        step(1'b0, 1'b0);
        check("hit_set", 32'(hit), 1);
        for (int i = 0; i < 12; i++) step(i[0], 1'b0);
        check("hit_lane_frozen", 32'(lane_y), 240);
        check("hit_car_frozen",  32'(car_x),  0);
        check("hit_sticky",      32'(hit),    1);
        step(1'b0, 1'b1);
        check("hit_reset", 32'(hit), 0);

        // Overlap and scroll in the same cycle: the scroll lands, then the hit.
        step(1'b1, 1'b0);
        check("ov_scroll_lane", 32'(lane_y), 242);
        check("ov_scroll_hit",  32'(hit),    1);

        // Collision box edges.
        foreach (vecs[k]) begin
            far_player();
            step(1'b0, 1'b1);
            player_x = 10'(vecs[k].px);
            player_y = 10'(vecs[k].py);
            step(1'b0, 1'b0);
            check($sformatf("edge_hit_%0d_%0d", vecs[k].px, vecs[k].py), 32'(hit), vecs[k].exp_hit);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
